lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller between the datapath and the data memory. It accepts one load or store request from the core, turns it into a word-aligned, byte-enabled memory transaction with a valid/ack handshake, and returns sign- or zero-extended load data. That returned data feeds the write-back select ahead of the register file. A timeout counter guarantees the core is always released.

## Interface
- `TIMEOUT`, default 16: maximum cycles `mem_req` is held without `mem_ack` before the access is aborted. Must be ≥ 1.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: core presents an access.
- `req_ready` output 1: block can accept an access. High only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `req_signed` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data; the relevant bits are LSB-aligned.
- `resp_valid` output 1: one-cycle pulse; the access is complete.
- `resp_rdata` output 32: formatted load data. 0 for stores and errors.
- `resp_err` output 1: qualified by `resp_valid`; indicates timeout, reserved size, or a misaligned access trap.
- `mem_req` output 1: memory transaction request.
- `mem_we` output 1: memory write.
- `mem_be` output 4: byte enables; bit i corresponds to byte lane i (little-endian).
- `mem_addr` output 32: `{req_addr[31:2], 2'b00}`.
- `mem_wdata` output 32: store data replicated across lanes.
- `mem_ack` input 1: memory completes the transaction in the same cycle it is asserted.
- `mem_rdata` input 32: read word; valid when `mem_ack` is high.

## Operation
- FSM states: IDLE, REQ, RESP.
  - IDLE → REQ: on `req_valid && req_ready` for a legal request. All request fields are captured into registers.
  - IDLE → RESP: on acceptance of an illegal request (size 11, or misaligned with the trap enabled). `resp_err=1` and no memory access is made.
  - REQ → RESP: on `mem_ack`, or when the timeout expires.
  - RESP → IDLE: unconditionally, after one cycle.
- Byte enables:
  - Byte access: a single lane, `addr[1:0]`.
  - Halfword access: lanes `{addr[1],0}` and the lane above it.
  - Word access: 4'b1111.
- Store data replication: byte = `{4{wdata[7:0]}}`, halfword = `{2{wdata[15:0]}}`, word = as-is.
- Load extraction: select the addressed byte or halfword from `mem_rdata`, then extend it to 32 bits according to the captured `req_signed`. Word loads pass through unchanged.
- The `mem_*` outputs are registered and stable for the whole of REQ. `mem_req` is 0 in every other state.
- Timeout counter:
  - Cleared on entry to REQ and increments on each REQ cycle without ack.
  - When the count reaches `TIMEOUT`−1 with no ack, the access ends with `resp_err=1` and `resp_rdata=0`.
  - If ack and timeout occur in the same cycle, the ack wins and the access completes normally.
- Stores: `resp_valid` pulses in RESP with `resp_rdata=0` and `resp_err=0`.
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_req=0`, `mem_we=0`, `mem_be=0`, `mem_addr=0`, `mem_wdata=0`, counter 0.
- Reset asserted mid-transaction: `mem_req` drops asynchronously and the FSM returns to IDLE. No response is issued.

## Timing
- Request accepted at edge T → `mem_req` high from T+1.
- `mem_ack` at the earliest during T+1 → `resp_valid` high for the cycle after the edge that sampled the ack (T+2) → `req_ready` high again at T+3.
- Minimum load/store latency is 2 cycles from acceptance to response. The core stalls while `req_ready` is low.
- Illegal request: `resp_valid` at T+1, `req_ready` at T+2.
- Timeout: `resp_valid` in the cycle after `TIMEOUT` REQ cycles.
- `req_valid` while not ready is ignored. The core must hold the request stable until it is accepted.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword access with `addr[0]=1`, or a word access with `addr[1:0]≠0`, is rejected with `resp_err=1`.
  - No memory access is made.
- Not defined:
  - The low address bits are forced to alignment (halfword `addr[0]` treated as 0; word `addr[1:0]` treated as 0).
  - The access proceeds normally and no error is raised for misalignment.

## Structure
- Package `lsu_pkg` holds:
  - Size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`/`SZ_RSVD`.
  - The FSM state enum.
- Sub-module `lsu_align` is purely combinational:
  - Store side: byte-enable generation and store-data replication.
  - Load side: lane extraction and sign/zero extension.
- `lsu_ctrl` holds the FSM, the request registers and the timeout counter.

## Test plan
- Word store to 0x100 with data 0xDEADBEEF, ack at T+1 → `mem_be`=1111, `mem_wdata`=0xDEADBEEF, `mem_addr`=0x100, `resp_valid` at T+2, `resp_err`=0.
- Signed byte load from 0x103 with `mem_rdata`=0x80112233 → `mem_be`=1000, `resp_rdata`=0xFFFFFF80. Repeated unsigned → 0x00000080.
- Halfword store to 0x202 with data 0x0000ABCD → `mem_be`=1100, `mem_wdata`=0xABCDABCD. Unsigned halfword load from 0x202 with `mem_rdata`=0x7FFF0000 → 0x00007FFF.
- `TIMEOUT`=4, `mem_ack` never asserted → `mem_req` high for exactly 4 cycles, then `resp_valid`=1 with `resp_err`=1 and `resp_rdata`=0. A second run with ack in the 4th cycle → normal completion.
- Word load from 0x101 → with the macro: `resp_err`=1 at T+1 and `mem_req` never rises. Without the macro: `mem_addr`=0x100, `mem_be`=1111, normal data.
- `rst_n` pulsed low during REQ → `mem_req`=0 immediately, no `resp_valid`, `req_ready`=1. The next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load lane
// extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be        = 4'b0000;
        st_wdata_rep = st_wdata;
        case (st_size)
            SZ_BYTE: begin
                st_be        = 4'b0001 << st_off;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be        = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            SZ_WORD: st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[7:0];
        case (ld_off)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: request capture, memory handshake FSM and timeout.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    lsu_state_e    state_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;
    logic          signed_q;
    logic [CntW-1:0] cnt_q;

    logic        req_illegal;
    logic [1:0]  st_off;
    logic [3:0]  st_be;
    logic [31:0] st_wdata_rep;
    logic [31:0] ld_data;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign req_illegal = (req_size == SZ_RSVD) || misalign;
`else
    assign req_illegal = (req_size == SZ_RSVD);
`endif

    // Low address bits forced to natural alignment for the access size.
    always_comb begin
        case (req_size)
            SZ_HALF: st_off = {req_addr[1], 1'b0};
            SZ_WORD: st_off = 2'b00;
            default: st_off = req_addr[1:0];
        endcase
    end

    lsu_align u_align (
        .st_size      (req_size),
        .st_off       (st_off),
        .st_wdata     (req_wdata),
        .st_be        (st_be),
        .st_wdata_rep (st_wdata_rep),
        .ld_size      (size_q),
        .ld_off       (off_q),
        .ld_signed    (signed_q),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            size_q     <= SZ_BYTE;
            off_q      <= 2'b00;
            signed_q   <= 1'b0;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_illegal) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state_q   <= StReq;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= st_be;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= st_wdata_rep;
                            size_q    <= req_size;
                            off_q     <= st_off;
                            signed_q  <= req_signed;
                            cnt_q     <= '0;
                        end
                    end
                end
                StReq: begin
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack) begin
                        state_q    <= StResp;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_we ? 32'h0 : ld_data;
                    end else if (cnt_q == CntLast) begin
                        state_q    <= StResp;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    state_q    <= StIdle;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized accesses
// compared against an arithmetic reference model.
module tb_lsu_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: number of bytes per access, lanes from arithmetic on the offset.
    function automatic logic [3:0] model_be(input int nb, input int off);
        int v;
        v = ((1 << nb) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int nb, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input int nb, input int off, input logic sgn,
                                               input logic [31:0] rd);
        longint unsigned mask;
        longint unsigned v;
        mask = (64'd1 << (8 * nb)) - 1;
        v = (64'(rd) >> (8 * off)) & mask;
        if (sgn && nb < 4 && v[8*nb-1]) v = v | (~mask);
        return v[31:0];
    endfunction

    // One complete access; ack_at is the REQ-cycle index (0-based) that carries mem_ack,
    // values >= TIMEOUT mean the memory never answers in time.
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_at);
        int nb, off, exp_cyc, ncyc;
        bit illegal, tmo;
        logic [31:0] exp_rdata;

        nb = 1 << size;
        illegal = (size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!illegal && (addr % nb) != 0) illegal = 1'b1;
`endif
        off = (int'(addr % 4) / nb) * nb;
        tmo = !illegal && (ack_at >= int'(TIMEOUT));
        exp_cyc = illegal ? 0 : (tmo ? int'(TIMEOUT) : ack_at + 1);
        exp_rdata = (illegal || tmo || we) ? 32'h0 : model_load(nb, off, sgn, rd);

        @(negedge clk);
        check_eq({tag, ":ready"}, req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        // Junk request while busy must be ignored.
        req_we    = $urandom;
        req_size  = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;

        ncyc = 0;
        for (int k = 0; k < int'(TIMEOUT) + 4; k++) begin
            @(negedge clk);
            if (resp_valid) break;
            ncyc++;
            check_eq({tag, ":mem_req"}, mem_req, 1);
            check_eq({tag, ":busy"}, req_ready, 0);
            check_eq({tag, ":mem_we"}, mem_we, we);
            check_eq({tag, ":mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            check_eq({tag, ":mem_be"}, mem_be, model_be(nb, off));
            if (we) check_eq({tag, ":mem_wdata"}, mem_wdata, model_wdata(nb, wd));
            mem_ack   = (k == ack_at);
            mem_rdata = mem_ack ? rd : $urandom;
        end
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        check_eq({tag, ":resp_valid"}, resp_valid, 1);
        check_eq({tag, ":req_cycles"}, ncyc, exp_cyc);
        check_eq({tag, ":resp_err"}, resp_err, (illegal || tmo) ? 1 : 0);
        check_eq({tag, ":resp_rdata"}, resp_rdata, exp_rdata);
        check_eq({tag, ":mem_req_off"}, mem_req, 0);
        @(negedge clk);
        check_eq({tag, ":pulse"}, resp_valid, 0);
        check_eq({tag, ":ready_again"}, req_ready, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst:req_ready", req_ready, 1);
        check_eq("rst:resp_valid", resp_valid, 0);
        check_eq("rst:resp_rdata", resp_rdata, 0);
        check_eq("rst:resp_err", resp_err, 0);
        check_eq("rst:mem_req", mem_req, 0);
        check_eq("rst:mem_we", mem_we, 0);
        check_eq("rst:mem_be", mem_be, 0);
        check_eq("rst:mem_addr", mem_addr, 0);
        check_eq("rst:mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;

        access("st_word", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        access("ld_sbyte", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233, 0);
        access("ld_ubyte", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233, 1);
        access("st_half", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 0);
        access("ld_uhalf", 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h7FFF0000, 0);
        access("ld_shalf", 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'h1234F00D, 2);
        access("timeout", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h55AA55AA, 100);
        access("ack_last", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h55AA55AA, TIMEOUT - 1);
        access("ld_mis_word", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hCAFEF00D, 0);
        access("st_mis_half", 1'b1, 2'b01, 1'b0, 32'h203, 32'h00001234, 32'h0, 0);
        access("rsvd_size", 1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 32'h0, 0);

        // Reset in the middle of REQ: mem_req drops at once, no response follows.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_rst:mem_req_before", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst:mem_req", mem_req, 0);
        check_eq("mid_rst:req_ready", req_ready, 1);
        check_eq("mid_rst:resp_valid", resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_rst:no_resp", resp_valid, 0);
            check_eq("mid_rst:idle_mem_req", mem_req, 0);
        end
        access("after_rst", 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'h0000F100, 0);

        for (int i = 0; i < 60; i++) begin
            int r;
            logic [1:0] sz;
            r  = $urandom_range(0, 9);
            sz = (r == 9) ? 2'b11 : 2'(r % 3);
            access("rand", 1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, TIMEOUT + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
